// File: rtl/fifo_rd_stream_pkg.sv
// ---------------------------------------------------------------------------
// fifo_rd_stream_pkg
// Shared constants for the FIFO read-side stream adapter.
//   BUF_DEPTH : number of entries in the output skid buffer
//   OCC_W     : width of the occupancy count (holds 0..BUF_DEPTH)
// ---------------------------------------------------------------------------
package fifo_rd_stream_pkg;

  localparam int BUF_DEPTH = 2;
  localparam int OCC_W     = $clog2(BUF_DEPTH + 1);

endpackage

// File: rtl/fifo_rd_stream_if.sv
// ---------------------------------------------------------------------------
// fifo_rd_stream_if
// Groups the FIFO read-port signals and the downstream valid/ready stream.
//   fifo_empty, fifo_data : from the FIFO read side
//   fifo_rd_en            : read request to the FIFO
//   flush                 : synchronous discard of buffered/in-flight words
//   m_valid, m_ready      : downstream stream handshake
//   m_data                : head word of the stream
//   occupancy             : words currently held in the output buffer
// Modport master is the adapter; modport slave is the surrounding system.
// ---------------------------------------------------------------------------
interface fifo_rd_stream_if
  import fifo_rd_stream_pkg::*;
#(
  parameter int width = 16
);

  logic             fifo_empty;
  logic [width-1:0] fifo_data;
  logic             fifo_rd_en;
  logic             flush;
  logic             m_valid;
  logic             m_ready;
  logic [width-1:0] m_data;
  logic [OCC_W-1:0] occupancy;

  modport master (
    input  fifo_empty,
    input  fifo_data,
    input  flush,
    input  m_ready,
    output fifo_rd_en,
    output m_valid,
    output m_data,
    output occupancy
  );

  modport slave (
    output fifo_empty,
    output fifo_data,
    output flush,
    output m_ready,
    input  fifo_rd_en,
    input  m_valid,
    input  m_data,
    input  occupancy
  );

endinterface

// File: rtl/fifo_rd_skid_buf.sv
// ---------------------------------------------------------------------------
// fifo_rd_skid_buf
// Two-entry pointer-based output buffer.
//   clk_r     : clock
//   reset     : asynchronous, active-low reset
//   wr_en     : write wr_data at the tail
//   wr_data   : word to store
//   pop       : head word consumed this cycle
//   flush     : empty the buffer (occupancy to 0, head realigned to tail)
//   occ       : words held (0..2)
//   head_data : word at the head, 0 when empty
// ---------------------------------------------------------------------------
module fifo_rd_skid_buf
  import fifo_rd_stream_pkg::*;
#(
  parameter int width = 16
) (
  input  logic             clk_r,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [width-1:0] wr_data,
  input  logic             pop,
  input  logic             flush,
  output logic [OCC_W-1:0] occ,
  output logic [width-1:0] head_data
);

  logic [width-1:0] mem [BUF_DEPTH];
  logic             head;
  logic             tail;

  // Pointer and count update. Flush wins over pop so a pop in the flush
  // cycle is ignored; moving head onto tail keeps the pointers coherent
  // without having to touch the storage.
  always_ff @(posedge clk_r or negedge reset) begin
    if (!reset) begin
      occ  <= '0;
      head <= 1'b0;
      tail <= 1'b0;
    end else if (flush) begin
      occ  <= '0;
      head <= tail;
    end else begin
      if (wr_en) tail <= ~tail;
      if (pop)   head <= ~head;
      occ <= occ + OCC_W'(wr_en) - OCC_W'(pop);
    end
  end

  // Storage has no reset; contents are only visible through head_data,
  // which is masked while the buffer is empty.
  always_ff @(posedge clk_r) begin
    if (wr_en && !flush) mem[tail] <= wr_data;
  end

  assign head_data = (occ == '0) ? '0 : mem[head];

endmodule

// File: rtl/fifo_rd_stream.sv
// ---------------------------------------------------------------------------
// fifo_rd_stream
// Converts the FIFO rd_en/empty port (read data valid one cycle after the
// request) into a first-word-fall-through valid/ready stream.
//   clk_r : read-domain clock
//   reset : asynchronous, active-low reset
//   bus   : fifo_rd_stream_if.master (FIFO read port, flush, stream side)
// ---------------------------------------------------------------------------
module fifo_rd_stream
  import fifo_rd_stream_pkg::*;
#(
  parameter int width = 16
) (
  input  logic             clk_r,
  input  logic             reset,
  fifo_rd_stream_if.master bus
);

  logic             inflight;
  logic             discard;
  logic             pop;
  logic             issue;
  logic             capture;
  logic [2:0]       pending;
  logic [OCC_W-1:0] occ;
  logic [width-1:0] head_data;

  assign pop = bus.m_valid & bus.m_ready;

  // A read may only be issued if the word it returns is guaranteed a slot:
  // words held plus the one still in flight, less the one leaving now.
  // pop implies occ >= 1, so the subtraction cannot underflow.
  assign pending = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
  assign issue   = reset & ~bus.flush & ~bus.fifo_empty & (pending < 3'd2);
  assign capture = inflight & ~discard & ~bus.flush;

  assign bus.fifo_rd_en = issue;

  // inflight marks that fifo_data carries a requested word this cycle.
  // discard remembers a flush so a word returning right after it is never
  // taken as part of the post-flush stream.
  always_ff @(posedge clk_r or negedge reset) begin
    if (!reset) begin
      inflight <= 1'b0;
      discard  <= 1'b0;
    end else begin
      inflight <= issue;
      discard  <= bus.flush;
    end
  end

  fifo_rd_skid_buf #(
    .width(width)
  ) u_buf (
    .clk_r    (clk_r),
    .reset    (reset),
    .wr_en    (capture),
    .wr_data  (bus.fifo_data),
    .pop      (pop),
    .flush    (bus.flush),
    .occ      (occ),
    .head_data(head_data)
  );

  assign bus.m_valid   = (occ != '0);
  assign bus.m_data    = head_data;
  assign bus.occupancy = occ;

endmodule
